// File: rtl/xs3_bcd_seq.sv
// Multi-digit excess-3 to BCD sequencer. A single shared nibble converter
// decodes one digit per clock, LSB digit first, between two valid/ready
// handshakes. Invalid excess-3 codes produce a zero digit and a per-digit flag.
module xs3_bcd_seq #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_xs3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [DIGITS-1:0]     out_err,
    output logic                  busy
);

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] sh_q, sh_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   err_q, err_d;

    logic                accept;
    logic                last_digit;
    logic [3:0]          conv_bcd;
    logic                conv_err;

    assign accept     = in_valid && (state_q == StIdle);
    assign last_digit = (idx_q == CNT_W'(DIGITS - 1));

    // Shared nibble converter; the current digit always sits in the low nibble.
    always_comb begin
        conv_bcd = 4'h0;
        conv_err = 1'b1;
        if (sh_q[3:0] >= 4'h3 && sh_q[3:0] <= 4'hC) begin
            conv_bcd = sh_q[3:0] - 4'h3;
            conv_err = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = StConvert;
            StConvert: if (last_digit) state_d = StDone;
            StDone:    if (out_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Handshake and status outputs are pure decodes of the state register.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
    end

    // Datapath next-state: capture on accept, write one result slot per convert cycle.
    always_comb begin
        idx_d = idx_q;
        sh_d  = sh_q;
        bcd_d = bcd_q;
        err_d = err_q;
        if (accept) begin
            idx_d = '0;
            sh_d  = in_xs3;
            bcd_d = '0;
            err_d = '0;
        end else if (state_q == StConvert) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (idx_q == CNT_W'(i)) begin
                    bcd_d[4*i +: 4] = conv_bcd;
                    err_d[i]        = conv_err;
                end
            end
            sh_d = sh_q >> 4;
            // Index parks at zero once the word is finished.
            idx_d = last_digit ? '0 : idx_q + CNT_W'(1);
        end
    end

    // Datapath registers; results are retained after DONE until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            sh_q  <= '0;
            bcd_q <= '0;
            err_q <= '0;
        end else begin
            idx_q <= idx_d;
            sh_q  <= sh_d;
            bcd_q <= bcd_d;
            err_q <= err_d;
        end
    end

    assign out_bcd = bcd_q;
    assign out_err = err_q;

endmodule

// File: doc/xs3_bcd_seq.md
Name: xs3_bcd_seq

Overview:
Multi-digit excess-3 to BCD conversion sequencer. It accepts a packed word of DIGITS excess-3 nibbles over a valid/ready handshake. A single shared 4-bit converter decodes one nibble per clock, LSB digit first. The result is presented as a packed BCD word with per-digit invalid-code flags on an output valid/ready handshake. It sits between the display/keypad data path and downstream BCD consumers (7-seg drivers, BCD arithmetic).

Parameters:
DIGITS, 4, number of 4-bit digits per word (legal 1..8)
CNT_W, 3, width of internal digit index; must satisfy 2**CNT_W >= DIGITS

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream word available
in_ready  output  1  block can accept a word (high only in IDLE)
in_xs3  input  4*DIGITS  packed excess-3 word; digit i = bits [4i+3:4i], digit 0 = LSB
out_valid  output  1  converted word available
out_ready  input  1  downstream accepts word
out_bcd  output  4*DIGITS  packed BCD result, same digit ordering
out_err  output  DIGITS  bit i set = digit i was an invalid excess-3 code
busy  output  1  high in CONVERT or DONE

Behaviour:
- One clock domain. Reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Per-digit conversion (combinational, single instance, shared across digits):
  - Codes 4'h3..4'hC are valid and map to bcd = code - 3 (4'h3 -> 0, 4'hC -> 9).
  - Codes 4'h0..4'h2 and 4'hD..4'hF are invalid: bcd digit = 4'h0 and the err bit is set.
- FSM states: IDLE, CONVERT, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_xs3 into an input shift register, clear the result and err registers, set idx=0, and go to CONVERT.
  - CONVERT: each cycle, convert digit idx and write its bcd/err into result slot idx, then idx++. After writing digit DIGITS-1, go to DONE. Exactly DIGITS cycles are spent in CONVERT.
  - DONE: out_valid=1, with out_bcd/out_err stable. On out_valid&&out_ready, go to IDLE. If out_ready is low, hold indefinitely with outputs unchanged.
- Latency: if the input handshake completes at edge k, out_valid goes high after edge k+DIGITS. out_valid and in_ready are never high in the same cycle.
- Throughput: one word per DIGITS+2 cycles maximum (accept, DIGITS converts, output handshake, IDLE re-accept).
- in_valid in CONVERT or DONE is ignored. in_xs3 is sampled only at the accept edge; later changes have no effect.
- Outputs are registered state decodes: in_ready=(state==IDLE), out_valid=(state==DONE), busy=!(state==IDLE).
- Reset values: state=IDLE, in_ready=1 (from the first cycle after reset), out_valid=0, busy=0, out_bcd=0, out_err=0, idx=0.
- Reset mid-operation (CONVERT or DONE): the partial or pending result is discarded and all registers return to reset values on that edge. No output handshake occurs for the aborted word.
- rst has priority over every handshake in the same cycle.
- out_bcd/out_err retain the last result after the DONE->IDLE transition until the next accept clears them. Consumers use them only while out_valid=1.
- DIGITS=1: CONVERT lasts 1 cycle and the latency is 1.

Test Plan:
- DIGITS=4, in_xs3=16'h4567 with out_ready=1 -> out_bcd=16'h1234, out_err=4'b0000, out_valid high exactly 4 cycles after the accept edge, for 1 cycle. in_ready is back to 1 on the next cycle.
- Boundary codes in_xs3=16'h3C3C -> out_bcd=16'h0909, err=0. Then in_xs3=16'h4F27 -> out_bcd=16'h1004, out_err=4'b0110.
- Backpressure: out_ready=0 for 10 cycles after DONE -> out_valid stays 1 and out_bcd is unchanged. in_valid pulsed with in_xs3=16'h3333 meanwhile is ignored (in_ready=0). After out_ready=1 and a single transfer, the 3333 word is accepted only when re-presented in IDLE.
- Reset mid-CONVERT: accept 16'h5555, assert rst at the 2nd convert cycle -> next cycle state IDLE, in_ready=1, out_valid=0, out_bcd=0, out_err=0. No output handshake for that word.
- Back-to-back: in_valid held high with words 16'h4567 then 16'h3C3C, out_ready=1 -> two results in order (16'h1234, 16'h0909), spaced DIGITS+2 cycles apart.
- Exhaustive per-digit: sweep all 16 codes on digit 0 -> bcd/err match the mapping table; digits 1..3 are set to 4'h3 and produce 0, no err.
